// File: rtl/beta_seq_ctrl_pkg.sv
// Shared types and constants for the Beta multi-cycle sequencer:
// state encodings, opcode values, PC source selects and instruction classes.
package beta_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [5:0] OP_LD  = 6'b011000;
  localparam logic [5:0] OP_ST  = 6'b011001;
  localparam logic [5:0] OP_JMP = 6'b011011;
  localparam logic [5:0] OP_BEQ = 6'b011100;
  localparam logic [5:0] OP_BNE = 6'b011101;
  localparam logic [5:0] OP_LDR = 6'b011111;

  localparam logic [1:0] OP_PFX_ALU  = 2'b10;
  localparam logic [1:0] OP_PFX_ALUC = 2'b11;

  localparam logic [1:0] PC_SRC_PCSEL    = 2'd0;
  localparam logic [1:0] PC_SRC_ILLOP    = 2'd1;
  localparam logic [1:0] PC_SRC_XADR     = 2'd2;
  localparam logic [1:0] PC_SRC_BUSFAULT = 2'd3;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_ALUC,
    CLS_LD,
    CLS_ST,
    CLS_JMP,
    CLS_BEQ,
    CLS_BNE,
    CLS_LDR
  } op_class_e;

  // Classes that need a data-memory phase after EXEC.
  function automatic logic is_mem_class(input op_class_e cls);
    return (cls == CLS_LD) || (cls == CLS_ST) || (cls == CLS_LDR);
  endfunction

endpackage

// File: rtl/beta_op_classify.sv
// Pure combinational decode of the IR opcode field into an instruction class
// and an illegal-opcode flag.
module beta_op_classify
  import beta_seq_ctrl_pkg::*;
(
  input  logic [5:0] ir_opcode,
  output op_class_e  op_class,
  output logic       illegal
);

  // NOTE: every output gets a default before the decode so no path can infer a latch.
  always_comb begin
    op_class = CLS_ALU;
    illegal  = 1'b0;
    if (ir_opcode[5:4] == OP_PFX_ALU) begin
      op_class = CLS_ALU;
    end else if (ir_opcode[5:4] == OP_PFX_ALUC) begin
      op_class = CLS_ALUC;
    end else begin
      case (ir_opcode)
        OP_LD:   op_class = CLS_LD;
        OP_ST:   op_class = CLS_ST;
        OP_JMP:  op_class = CLS_JMP;
        OP_BEQ:  op_class = CLS_BEQ;
        OP_BNE:  op_class = CLS_BNE;
        OP_LDR:  op_class = CLS_LDR;
        default: illegal  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/beta_seq_ctrl.sv
// Multi-cycle instruction sequencer for the Beta core: walks FETCH/DECODE/EXEC/
// MEM/WB, runs the memory handshakes and forces traps on ILLOP, bus fault or irq.
module beta_seq_ctrl
  import beta_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       ir_opcode,
  input  logic             irq,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_load,
  output logic             pc_load,
  output logic             rf_we,
  output logic [1:0]       pc_src,
  output logic             trap_active,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int              TO_W    = $clog2(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             fetch_entry_q, fetch_entry_d;
  op_class_e        cls_q, cls_d;
  logic [1:0]       trap_src_q, trap_src_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] instret_q;

  op_class_e        dec_class;
  logic             dec_illegal;

  beta_op_classify u_classify (
    .ir_opcode (ir_opcode),
    .op_class  (dec_class),
    .illegal   (dec_illegal)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      fetch_entry_q <= 1'b1;
      cls_q         <= CLS_ALU;
      trap_src_q    <= PC_SRC_PCSEL;
      to_cnt_q      <= '0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_entry_q <= fetch_entry_d;
      cls_q         <= cls_d;
      trap_src_q    <= trap_src_d;
      to_cnt_q      <= to_cnt_d;
      if (state_q == ST_WB) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_entry_d = 1'b0;
    cls_d         = cls_q;
    trap_src_d    = trap_src_q;
    to_cnt_d      = '0;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_load       = 1'b0;
    rf_we         = 1'b0;
    pc_src        = PC_SRC_PCSEL;
    trap_active   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // irq only counts on the first FETCH cycle; later it waits for the next instruction.
        if (fetch_entry_q && irq) begin
          state_d    = ST_TRAP;
          trap_src_d = PC_SRC_XADR;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = ST_DECODE;
          end else if (to_cnt_q == TO_LAST) begin
            state_d    = ST_TRAP;
            trap_src_d = PC_SRC_BUSFAULT;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      ST_DECODE: begin
        cls_d = dec_class;
        if (dec_illegal) begin
          state_d    = ST_TRAP;
          trap_src_d = PC_SRC_ILLOP;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = is_mem_class(cls_q) ? ST_MEM : ST_WB;
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_ST);
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (to_cnt_q == TO_LAST) begin
          state_d    = ST_TRAP;
          trap_src_d = PC_SRC_BUSFAULT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_WB: begin
        pc_load       = 1'b1;
        rf_we         = (cls_q != CLS_ST);
        state_d       = ST_FETCH;
        fetch_entry_d = 1'b1;
      end

      ST_TRAP: begin
        trap_active   = 1'b1;
        rf_we         = 1'b1;
        pc_load       = 1'b1;
        pc_src        = trap_src_q;
        state_d       = ST_FETCH;
        fetch_entry_d = 1'b1;
      end

      default: begin
        state_d       = ST_FETCH;
        fetch_entry_d = 1'b1;
      end
    endcase

    // Keep the fetch port quiet while reset is held so no request leaks out.
    if (reset) begin
      imem_req = 1'b0;
      ir_load  = 1'b0;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_beta_seq_ctrl.sv
// Self-checking bench for beta_seq_ctrl: a driver issues instructions with
// configurable memory wait states, a monitor counts per-instruction activity
// and compares it against expected records queued by the driver.
module tb_beta_seq_ctrl;
  import beta_seq_ctrl_pkg::*;

  localparam int MT = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    ir_opcode = 6'b0;
  logic          irq = 1'b0;
  logic          imem_req, imem_ack;
  logic          dmem_req, dmem_we, dmem_ack;
  logic          ir_load, pc_load, rf_we;
  logic [1:0]    pc_src;
  logic          trap_active;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  beta_seq_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ir_opcode   (ir_opcode),
    .irq         (irq),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .ir_load     (ir_load),
    .pc_load     (pc_load),
    .rf_we       (rf_we),
    .pc_src      (pc_src),
    .trap_active (trap_active),
    .state       (state),
    .instret     (instret)
  );

  op_class_e tcls;
  logic      tcls_ill;
  beta_op_classify u_tb_cls (.ir_opcode(ir_opcode), .op_class(tcls), .illegal(tcls_ill));

  // Memory responders: ack after a programmed number of waiting cycles (-1 = never).
  int   imem_wait = 0, dmem_wait = 0;
  int   icnt = 0, dcnt = 0;
  logic ack_tie = 1'b0, dack_force = 1'b0;

  always @(posedge clk) begin
    icnt <= imem_req ? icnt + 1 : 0;
    dcnt <= dmem_req ? dcnt + 1 : 0;
  end

  assign imem_ack = ack_tie  | (imem_req && imem_wait >= 0 && icnt == imem_wait);
  assign dmem_ack = dack_force | (dmem_req && dmem_wait >= 0 && dcnt == dmem_wait);

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         cycles;
    int         n_ireq;
    int         n_irl;
    int         n_dreq;
    int         n_dwe;
    int         n_rf;
    logic [1:0] pc_src;
    logic       trap;
  } exp_t;

  exp_t sb_q[$];

  function automatic void bench_decode(input logic [5:0] op, output bit ill,
                                       output bit mem, output bit st);
    ill = !(op[5] || op == 6'b011000 || op == 6'b011001 || op == 6'b011011 ||
            op == 6'b011100 || op == 6'b011101 || op == 6'b011111);
    mem = (op == 6'b011000) || (op == 6'b011001) || (op == 6'b011111);
    st  = (op == 6'b011001);
  endfunction

  function automatic exp_t model(input logic [5:0] op, input int iw, input int dw,
                                 input bit irq_e);
    exp_t e;
    bit   ill, mem, st;
    int   f;
    bench_decode(op, ill, mem, st);
    e = '{default: 0};
    if (irq_e) begin
      e.cycles = 2; e.n_rf = 1; e.pc_src = 2'd2; e.trap = 1'b1;
      return e;
    end
    if (iw < 0) begin
      e.cycles = MT + 1; e.n_ireq = MT; e.n_rf = 1; e.pc_src = 2'd3; e.trap = 1'b1;
      return e;
    end
    f = iw + 1;
    e.n_ireq = f;
    e.n_irl  = 1;
    if (ill) begin
      e.cycles = f + 2; e.n_rf = 1; e.pc_src = 2'd1; e.trap = 1'b1;
    end else if (mem && dw < 0) begin
      e.cycles = f + 3 + MT; e.n_dreq = MT; e.n_dwe = st ? MT : 0;
      e.n_rf = 1; e.pc_src = 2'd3; e.trap = 1'b1;
    end else if (mem) begin
      e.cycles = f + dw + 4; e.n_dreq = dw + 1; e.n_dwe = st ? dw + 1 : 0;
      e.n_rf = st ? 0 : 1;
    end else begin
      e.cycles = f + 3; e.n_rf = 1;
    end
    return e;
  endfunction

  // Monitor: accumulate activity per instruction, compare when pc_load marks its end.
  int          cyc = 0, c_ireq = 0, c_irl = 0, c_dreq = 0, c_dwe = 0, c_rf = 0;
  int          ev_count = 0;
  logic [CW-1:0] ret_model = '0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      cyc = 0; c_ireq = 0; c_irl = 0; c_dreq = 0; c_dwe = 0; c_rf = 0;
      ret_model = '0;
    end else begin
      cyc++;
      c_ireq += int'(imem_req);
      c_irl  += int'(ir_load);
      c_dreq += int'(dmem_req);
      c_dwe  += int'(dmem_we);
      c_rf   += int'(rf_we);
      if (pc_load) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("cycles",    cyc,         e.cycles);
          check("imem_req",  c_ireq,      e.n_ireq);
          check("ir_load",   c_irl,       e.n_irl);
          check("dmem_req",  c_dreq,      e.n_dreq);
          check("dmem_we",   c_dwe,       e.n_dwe);
          check("rf_we",     c_rf,        e.n_rf);
          check("pc_src",    pc_src,      e.pc_src);
          check("trap",      trap_active, e.trap);
          check("state_end", state,       e.trap ? 32'd5 : 32'd4);
          check("instret",   instret,     ret_model);
          if (!e.trap) ret_model = ret_model + CW'(1);
        end
        cyc = 0; c_ireq = 0; c_irl = 0; c_dreq = 0; c_dwe = 0; c_rf = 0;
        ev_count++;
      end
    end
  end

  task automatic start(input logic [5:0] op, input int iw, input int dw, input bit irq_e);
    bit ill, mem, st;
    ir_opcode = op;
    imem_wait = iw;
    dmem_wait = dw;
    irq       = irq_e;
    #1;
    bench_decode(op, ill, mem, st);
    check("cls_illegal", tcls_ill, ill);
    if (!ill) check("cls_mem", is_mem_class(tcls), mem);
    sb_q.push_back(model(op, iw, dw, irq_e));
  endtask

  task automatic wait_done();
    int start_ev = ev_count;
    for (int i = 0; i < 60 && ev_count == start_ev; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_in_time", ev_count != start_ev, 1'b1);
    if (ev_count == start_ev) begin
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    irq = 1'b0;
  endtask

  task automatic run(input logic [5:0] op, input int iw, input int dw, input bit irq_e);
    start(op, iw, dw, irq_e);
    wait_done();
  endtask

  logic [5:0] legal_ops [10] = '{6'b100000, 6'b101111, 6'b110000, 6'b111111, 6'b011000,
                                 6'b011001, 6'b011011, 6'b011100, 6'b011101, 6'b011111};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state",    state,       32'd0);
    check("rst_imem_req", imem_req,    32'd0);
    check("rst_dmem_req", dmem_req,    32'd0);
    check("rst_dmem_we",  dmem_we,     32'd0);
    check("rst_ir_load",  ir_load,     32'd0);
    check("rst_pc_load",  pc_load,     32'd0);
    check("rst_rf_we",    rf_we,       32'd0);
    check("rst_trap",     trap_active, 32'd0);
    check("rst_pc_src",   pc_src,      32'd0);
    check("rst_instret",  instret,     32'd0);

    // ALU with imem_ack tied high: 4-cycle period, stray acks outside FETCH ignored.
    ack_tie = 1'b1;
    start(6'b100000, 0, 0, 0);
    @(posedge clk); #1; reset = 1'b0;
    wait_done();
    run(6'b100000, 0, 0, 0);
    ack_tie = 1'b0;

    run(6'b110101, 1, 0, 0);   // ALUC, one fetch wait
    run(6'b011000, 0, 3, 0);   // LD, ack on the timeout cycle wins
    run(6'b011001, 0, 1, 0);   // ST
    run(6'b011111, 1, 0, 0);   // LDR
    run(6'b011011, 0, 0, 0);   // JMP
    run(6'b011100, 0, 0, 0);   // BEQ
    run(6'b011101, 2, 0, 0);   // BNE
    run(6'b000000, 0, 0, 0);   // illegal
    run(6'b011010, 1, 0, 0);   // illegal inside the 01 space
    run(6'b011000, 0, -1, 0);  // LD bus fault
    run(6'b011001, 0, -1, 0);  // ST bus fault
    run(6'b100000, -1, 0, 0);  // fetch bus fault
    run(6'b100000, 0, 0, 1);   // irq at FETCH entry

    // irq raised after FETCH entry is ignored for this instruction.
    start(6'b100001, 2, 0, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    irq = 1'b1;
    wait_done();

    for (int k = 0; k < 8; k++) begin
      run(legal_ops[$urandom_range(0, 9)], int'($urandom_range(0, 2)),
          int'($urandom_range(0, 3)), 0);
    end

    // Reset in the middle of a data-memory wait, with a late ack afterwards.
    start(6'b011000, 0, -1, 0);
    repeat (4) @(negedge clk);
    #1;
    reset      = 1'b1;
    dack_force = 1'b1;
    @(negedge clk); #1;
    sb_q.delete();
    check("mrst_state",    state,    32'd0);
    check("mrst_dmem_req", dmem_req, 32'd0);
    check("mrst_dmem_we",  dmem_we,  32'd0);
    check("mrst_imem_req", imem_req, 32'd0);
    check("mrst_instret",  instret,  32'd0);
    start(6'b011100, 0, 0, 0);
    @(posedge clk); #1; reset = 1'b0;
    wait_done();
    dack_force = 1'b0;
    run(6'b011000, 1, 2, 0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
